// File: rtl/pc_next_unit.sv
// Program-counter unit: owns the fetch PC and selects between PC+4 and
// N prioritised redirect channels. Optional statistics counters: PC_NEXT_STATS_EN.
module pc_next_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      N_REDIR      = 3,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    fetch_ready_i,
  input  logic [N_REDIR-1:0]      redir_valid_i,
  input  logic [N_REDIR*XLEN-1:0] redir_target_i,
  output logic [XLEN-1:0]         pc_o,
  output logic                    pc_valid_o,
  output logic [XLEN-1:0]         pc_plus4_o,
  output logic                    redir_taken_o,
  output logic                    misalign_o,
`ifdef PC_NEXT_STATS_EN
  output logic [31:0]             stat_redir_o,
  output logic [31:0]             stat_stall_o,
`endif
  output logic [1:0]              state_o
);

  // Fetch handshake: pc_o is a request while pc_valid_o=1; it is accepted on
  // a cycle with pc_valid_o && fetch_ready_i, and pc_o holds until then.

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            taken_q, taken_d;
  logic            any_redir;
  logic [XLEN-1:0] sel_raw;
  logic [XLEN-1:0] sel_target;

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    any_redir = 1'b0;
    sel_raw   = '0;
    for (int k = N_REDIR - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        any_redir = 1'b1;
        sel_raw   = redir_target_i[k*XLEN +: XLEN];
      end
    end
  end

  assign sel_target = {sel_raw[XLEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    taken_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (any_redir) begin
          pc_d    = sel_target;
          taken_d = 1'b1;
        end
      end
      RUN: begin
        if (any_redir && fetch_ready_i) begin
          pc_d    = sel_target;
          taken_d = 1'b1;
        end else if (any_redir) begin
          pend_d  = sel_target;
          state_d = PEND;
        end else if (fetch_ready_i && !stall_i) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      PEND: begin
        if (fetch_ready_i) begin
          pc_d    = any_redir ? sel_target : pend_q;
          taken_d = 1'b1;
          state_d = RUN;
        end else if (any_redir) begin
          pend_d = sel_target;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      taken_q <= taken_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_valid_o    = (state_q != BOOT);
  assign pc_plus4_o    = pc_q + XLEN'(4);
  assign redir_taken_o = taken_q;
  // Flag follows the raw target in the cycle it is sampled; forced low in reset.
  assign misalign_o    = any_redir && (sel_raw[1:0] != 2'b00) && !rst;
  assign state_o       = state_q;

`ifdef PC_NEXT_STATS_EN
  logic [31:0] stat_redir_q, stat_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_redir_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (taken_d && stat_redir_q != 32'hFFFF_FFFF)
        stat_redir_q <= stat_redir_q + 32'd1;
      if (state_q == RUN && stall_i && !any_redir && stat_stall_q != 32'hFFFF_FFFF)
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_redir_o = stat_redir_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-generation program-counter unit for the RISC_V core.
- Owns the PC register and selects the next PC from sequential PC+4 or N prioritised redirect sources (branch/jump, trap, return, ...).
- Redirects that arrive while the current fetch is unaccepted are buffered.
- Sits between the execute/CSR redirect logic and the instruction-fetch port; replaces the 2:1 next-PC mux and the standalone PC register.

Parameters:
XLEN, 32, PC/address width in bits
N_REDIR, 3, number of redirect request channels (channel 0 = highest priority), >=1
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits, must be 4-byte aligned)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  pipeline stall from hazard unit; blocks sequential advance only
fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
redir_valid_i  in  N_REDIR  per-channel redirect request
redir_target_i  in  N_REDIR*XLEN  packed targets, channel k at [k*XLEN +: XLEN]
pc_o  out  XLEN  current fetch address
pc_valid_o  out  1  pc_o is a valid fetch request
pc_plus4_o  out  XLEN  pc_o + 4, for link-register writeback
redir_taken_o  out  1  one-cycle pulse: PC loaded from a redirect this edge
misalign_o  out  1  one-cycle pulse: selected redirect target had [1:0] != 0

Behaviour:
- Reset (async assert, any state): pc_o=RESET_VECTOR, pc_valid_o=0, redir_taken_o=0, misalign_o=0, pending register=0, state=BOOT.
- pc_plus4_o = pc_o + 4, combinational, truncated to XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect select, combinational:
  - Lowest-index asserted channel wins.
  - sel_target[1:0] forced to 2'b00.
  - misalign_o = 1 in the sampling cycle if the original target bits [1:0] != 0.
- Handshake:
  - A request is accepted when pc_valid_o && fetch_ready_i.
  - pc_o must stay stable while pc_valid_o=1 and the request is unaccepted.
- States:
  - BOOT: pc_valid_o=0. Always goes to RUN next edge. A redirect seen in BOOT loads pc_o directly (pulse redir_taken_o).
  - RUN: pc_valid_o=1. Per edge, in priority order:
    1. Any redirect and fetch_ready_i=1 -> pc_o<=sel_target, redir_taken_o pulses, stay RUN.
    2. Any redirect and fetch_ready_i=0 -> pend<=sel_target, go to PEND; pc_o unchanged.
    3. fetch_ready_i=1 and stall_i=0 -> pc_o<=pc_o+4.
    4. Otherwise hold.
  - PEND: pc_valid_o=1, pc_o unchanged.
    - A new redirect while fetch_ready_i=0 overwrites pend; the newest redirect wins.
    - On fetch_ready_i=1, pc_o<=(new redirect this cycle ? sel_target : pend), redir_taken_o pulses, go to RUN.
- stall_i never blocks or delays a redirect; redirects act as flush.
- Latency: a redirect presented in cycle t (fetch accepted) makes pc_o = target after the edge ending cycle t.
- Reset mid-PEND discards pend; pc_o returns to RESET_VECTOR.

Optional Feature:
Macro PC_NEXT_STATS_EN.
- Defined: adds outputs stat_redir_o [31:0] and stat_stall_o [31:0].
  - stat_redir_o increments on every redir_taken_o.
  - stat_stall_o increments each RUN cycle with stall_i=1 and no redirect.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_VECTOR=0x100, fetch_ready_i=1 -> cycle 1: pc_valid_o=0, pc_o=0x100; then pc_o=0x100,0x104,0x108 on successive cycles.
- Stall: stall_i=1 for 3 cycles at pc_o=0x20 -> pc_o holds 0x20; after release -> 0x24 next cycle. Stall plus channel-1 redirect to 0x80 -> pc_o=0x80, redir_taken_o=1.
- Priority: redir_valid_i=3'b110 with targets ch1=0x200, ch2=0x300 -> pc_o=0x200. Then 3'b111 with ch0=0x400 -> pc_o=0x400.
- Pending: fetch_ready_i=0 at pc_o=0x40, redirect to 0x90 -> pc_o stays 0x40. Second redirect to 0xA0 while still not ready -> on ready, pc_o=0xA0 with one redir_taken_o pulse.
- Misaligned/wrap: redirect target 0x1003 -> misalign_o=1, pc_o=0x1000. Sequential from 0xFFFF_FFFC -> pc_o=0x0, pc_plus4_o=0x4.
- Async reset asserted mid-PEND (pend=0x90) -> outputs return to reset values immediately, without a clock edge; after release, fetch restarts at RESET_VECTOR. With PC_NEXT_STATS_EN, counters read 0.
